// File: rtl/hilo_muldiv_if.sv
// Operand/result bundle between the execute stage and the HI/LO multiply-divide unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, mthi, mtlo, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shift-add or restoring
// step per cycle on magnitudes, with sign correction in a final FIX cycle.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    hilo_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic               is_div_q, neg_q, neg_r, div0;
    logic [WIDTH-1:0]   mreg;
    logic [2*WIDTH-1:0] acc;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quot, rem;

    assign accept = (state == IDLE) && bus.start;
    assign sgn    = ~bus.op[0];
    assign a_neg  = sgn & bus.a[WIDTH-1];
    assign b_neg  = sgn & bus.b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mreg} : '0);
    assign div_trial = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_trial >= {1'b0, mreg};
    assign div_diff  = div_trial - {1'b0, mreg};
    assign acc_step  = is_div_q
                     ? {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]), acc[WIDTH-2:0], div_ge}
                     : {mul_sum, acc[WIDTH-1:1]};

    assign prod = neg_q ? -acc : acc;
    assign quot = acc[WIDTH-1:0];
    assign rem  = acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            mreg     <= '0;
            acc      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        is_div_q <= bus.op[1];
                        // a zero divisor forces an all-ones quotient, so its sign is never applied
                        div0     <= bus.op[1] && (bus.b == '0);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= bus.op[1] & a_neg;
                        mreg     <= bus.op[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_step;
                end
                FIX: begin
                    if (is_div_q) begin
                        lo_q <= div0 ? '1 : (neg_q ? -quot : quot);
                        hi_q <= neg_r ? -rem : rem;
                    end else begin
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed checks of hilo_muldiv: arithmetic corners, latency, moves, ignored starts, reset abort.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hilo_muldiv_if #(.WIDTH(W)) bus ();

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op; optionally injects start+mthi (ignored while busy) at inj cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int inj);
        logic [W-1:0] hi0, lo0;
        bit stable = 1'b1;
        int lat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        hi0 = bus.hi; lo0 = bus.lo;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.mthi = 1'b0;
            bus.a = 'x; bus.b = 'x;
            if (cyc == 0) chk({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
            if (bus.done) begin lat = cyc; break; end
            if (bus.hi !== hi0 || bus.lo !== lo0) stable = 1'b0;
            if (cyc == inj) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'hDEAD;
                bus.op = 2'd1; bus.a = 32'd9; bus.b = 32'd9;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'd33);
        chk({tag, " hilo_stable"}, 64'(stable), 64'd1);
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst hi", 64'(bus.hi), 64'd0);
        chk("rst lo", 64'(bus.lo), 64'd0);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);

        run_op("mult",     2'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, -1);
        run_op("multu",    2'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, -1);
        run_op("div_neg",  2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("divu",     2'd3, 32'd100,      32'd7, 32'd2,        32'd14,       -1);
        run_op("divu_z",   2'd3, 32'h1234,     32'd0, 32'h1234,     32'hFFFFFFFF, -1);
        run_op("div_z",    2'd2, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, -1);
        run_op("div_ovf",  2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, -1);
        run_op("mult_ss",  2'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 32'd15,       -1);

        // idle moves, single and paired
        @(negedge clk);
        bus.mthi = 1'b1; bus.wdata = 32'hAAAA5555;
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("mthi hi", 64'(bus.hi), 64'hAAAA5555);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0BADF00D;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("both hi", 64'(bus.hi), 64'h0BADF00D);
        chk("both lo", 64'(bus.lo), 64'h0BADF00D);

        run_op("mult_inj", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 9);

        // reset lands on the 20th edge of an in-flight DIVU
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort hi", 64'(bus.hi), 64'd0);
        chk("abort lo", 64'(bus.lo), 64'd0);
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        run_op("post_rst", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
